// File: rtl/ring_osc_meter_if.sv
// ring_osc_meter_if: request/result bundle of the ring-oscillator frequency meter.
//
// Signals
//   start     request level from a button; asynchronous, synchronised inside the meter
//   ch_sel    channel to measure, sampled when a request is accepted
//   busy      high from acceptance until the measurement finishes
//   done      one-cycle pulse when count/overflow are updated
//   count     rising edges of the selected ring within the last gate window
//   overflow  edge counter saturated during the last window
//   probe     raw output of the currently enabled ring (0 when none)
//   led       copy of busy
//
// Modports: master drives the request side, slave is the meter itself.
`timescale 1ns/1ps
interface ring_osc_meter_if #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned CNT_WIDTH    = 24
);
  localparam int unsigned SelWidth = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic                 start;
  logic [SelWidth-1:0]  ch_sel;
  logic                 busy;
  logic                 done;
  logic [CNT_WIDTH-1:0] count;
  logic                 overflow;
  logic                 probe;
  logic                 led;

  modport master (
    output start, ch_sel,
    input  busy, done, count, overflow, probe, led
  );

  modport slave (
    input  start, ch_sel,
    output busy, done, count, overflow, probe, led
  );
endinterface

// File: rtl/ring_osc_meter.sv
// ring_osc_meter: bank of gated ring oscillators plus an on-chip frequency meter.
//
// One channel runs at a time; its rising edges are counted over a window of GATE_CYCLES
// clk cycles, and the result is latched on count/overflow with a one-cycle done pulse.
// The enabled ring is also routed raw to probe for an oscilloscope.
//
// Ports
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    ring_osc_meter_if.slave: start, ch_sel in; busy, done, count, overflow,
//          probe, led out
//
// Optional feature: define RO_CONTINUOUS_EN to keep re-measuring the same channel for
// as long as the synchronised start level stays high. Without it the meter is single-shot.
//
// The ring frequency must stay below clk/4 so the 2-FF synchroniser plus edge detector
// sees every rising edge.
`timescale 1ns/1ps
module ring_osc_meter #(
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned NUM_INVERTERS = 283,
  parameter int unsigned GATE_CYCLES   = 100000,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_WIDTH     = 24,
  parameter real         GATE_DELAY    = 0.1
) (
  input logic            clk,
  input logic            rst_n,
  ring_osc_meter_if.slave bus
);

  localparam int unsigned SelWidth   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned TimerMax   = (GATE_CYCLES > SETTLE_CYCLES + 1) ?
                                       GATE_CYCLES : SETTLE_CYCLES + 1;
  localparam int unsigned TimerWidth = $clog2(TimerMax);
  localparam int unsigned SettleLd   = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  localparam logic [TimerWidth-1:0] SettleLoad = TimerWidth'(SettleLd);
  localparam logic [TimerWidth-1:0] GateLoad   = TimerWidth'(GATE_CYCLES - 1);

  // An even ring would latch instead of oscillate.
  if ((NUM_INVERTERS % 2) == 0) begin : g_even_ring_error
    $error("ring_osc_meter: NUM_INVERTERS must be odd");
  end

  typedef enum logic [1:0] {StIdle, StSettle, StCount, StDone} state_e;

  state_e                  r_state;
  logic [NUM_CHANNELS-1:0] r_en;
  logic                    r_busy;
  logic                    r_done;
  logic [CNT_WIDTH-1:0]    r_count;
  logic                    r_overflow;
  logic [TimerWidth-1:0]   r_timer;
  logic [CNT_WIDTH-1:0]    r_edge_cnt;
  logic                    r_sat;

  logic [1:0]              r_start_sync;
  logic                    r_start_prev;
  logic [1:0]              r_ro_sync;
  logic                    r_ro_prev;

  logic [NUM_CHANNELS-1:0] w_tap;
  logic [NUM_CHANNELS-1:0] w_en_sel;
  logic                    w_probe;
  logic                    w_start_re;
  logic                    w_ro_re;

  // ---------------------------------------------------------------------------
  // Ring oscillators: one AND stage (enable) closing a chain of inverters.
  // The tap is the AND output, so a disabled ring reads 0 rather than the
  // idle-high level at the end of an odd inverter chain.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ring
    (* dont_touch = "yes" *) wire [NUM_INVERTERS:0] w_node;

    assign #(GATE_DELAY) w_node[0] = r_en[k] & w_node[NUM_INVERTERS];

    for (genvar i = 0; i < NUM_INVERTERS; i++) begin : g_inv
      assign #(GATE_DELAY) w_node[i+1] = ~w_node[i];
    end

    assign w_tap[k] = w_node[0];
  end

  // At most one ring is enabled, so OR-ing the taps selects it.
  assign w_probe = |w_tap;

  // Out-of-range channel numbers enable nothing; the window still runs and reports 0.
  always_comb begin
    w_en_sel = '0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      if (bus.ch_sel == SelWidth'(k)) w_en_sel[k] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Synchronisers and rising-edge detectors for start and the ring tap.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_sync <= '0;
      r_start_prev <= 1'b0;
      r_ro_sync    <= '0;
      r_ro_prev    <= 1'b0;
    end else begin
      r_start_sync <= {r_start_sync[0], bus.start};
      r_start_prev <= r_start_sync[1];
      r_ro_sync    <= {r_ro_sync[0], w_probe};
      r_ro_prev    <= r_ro_sync[1];
    end
  end

  assign w_start_re = r_start_sync[1] & ~r_start_prev;
  assign w_ro_re    = r_ro_sync[1] & ~r_ro_prev;

  // ---------------------------------------------------------------------------
  // Measurement FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_en       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_timer    <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // busy drops one cycle after DONE so it overlaps the done pulse.
          r_busy <= 1'b0;
          if (w_start_re) begin
            r_en    <= w_en_sel;
            r_busy  <= 1'b1;
            r_timer <= SettleLoad;
            r_state <= StSettle;
          end
        end

        StSettle: begin
          r_edge_cnt <= '0;
          r_sat      <= 1'b0;
          if (r_timer == '0) begin
            r_timer <= GateLoad;
            r_state <= StCount;
          end else begin
            r_timer <= r_timer - TimerWidth'(1);
          end
        end

        StCount: begin
          // The edge seen on the last COUNT cycle is still counted here.
          if (w_ro_re) begin
            if (&r_edge_cnt) r_sat <= 1'b1;
            else             r_edge_cnt <= r_edge_cnt + CNT_WIDTH'(1);
          end
          if (r_timer == '0) r_state <= StDone;
          else               r_timer <= r_timer - TimerWidth'(1);
        end

        StDone: begin
          r_count    <= r_edge_cnt;
          r_overflow <= r_sat;
          r_done     <= 1'b1;
`ifdef RO_CONTINUOUS_EN
          if (r_start_sync[1]) begin
            // One extra settle cycle stands in for the acceptance cycle, keeping the
            // back-to-back cadence equal to the single-shot latency.
            r_timer <= TimerWidth'(SETTLE_CYCLES);
            r_state <= StSettle;
          end else begin
            r_en    <= '0;
            r_state <= StIdle;
          end
`else
          r_en    <= '0;
          r_state <= StIdle;
`endif
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.led      = r_busy;
  assign bus.done     = r_done;
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;
  assign bus.probe    = w_probe;

endmodule

// File: tb/tb_ring_osc_meter.sv
`timescale 1ns/1ps
module tb_ring_osc_meter;

  localparam int unsigned NumCh     = 3;
  localparam int unsigned NumInv    = 49;
  localparam real         GateDly   = 1.0;
  localparam int unsigned Gate      = 1000;
  localparam int unsigned Settle    = 16;
  localparam int unsigned CntW      = 24;
  localparam int unsigned CntWSmall = 6;
  localparam real         ClkPeriod = 10.0;
  // A ring of N inverters plus one AND stage has period 2 * (N + 1) * gate delay.
  localparam real         RingPeriod = 2.0 * (NumInv + 1) * GateDly;
  // Cycles from the first busy sample to the done sample: start_re->done minus one.
  localparam int          DoneLat   = 1 + Settle + Gate;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  ring_osc_meter_if #(.NUM_CHANNELS(NumCh), .CNT_WIDTH(CntW))      u_if  ();
  ring_osc_meter_if #(.NUM_CHANNELS(NumCh), .CNT_WIDTH(CntWSmall)) u_if6 ();

  ring_osc_meter #(
    .NUM_CHANNELS (NumCh),
    .NUM_INVERTERS(NumInv),
    .GATE_CYCLES  (Gate),
    .SETTLE_CYCLES(Settle),
    .CNT_WIDTH    (CntW),
    .GATE_DELAY   (GateDly)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if)
  );

  ring_osc_meter #(
    .NUM_CHANNELS (NumCh),
    .NUM_INVERTERS(NumInv),
    .GATE_CYCLES  (Gate),
    .SETTLE_CYCLES(Settle),
    .CNT_WIDTH    (CntWSmall),
    .GATE_DELAY   (GateDly)
  ) u_dut6 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: expected edge count from ring/clock periods, then saturation.
  // ---------------------------------------------------------------------------
  function automatic int model_edges(input int ch);
    if (ch >= int'(NumCh)) return 0;
    return int'(Gate * ClkPeriod / RingPeriod);
  endfunction

  function automatic int model_sat(input int n, input int w);
    int max_v;
    max_v = (1 << w) - 1;
    return (n > max_v) ? max_v : n;
  endfunction

  function automatic bit model_ovf(input int n, input int w);
    return n > ((1 << w) - 1);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo,
                             input longint hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  task automatic set_start(input logic v);
    u_if.start  = v;
    u_if6.start = v;
  endtask

  task automatic set_ch(input logic [1:0] v);
    u_if.ch_sel  = v;
    u_if6.ch_sel = v;
  endtask

  // Assert start asynchronously for ~2 cycles and wait for busy; returns 0 on timeout.
  task automatic request(input logic [1:0] ch, input bit keep, output bit ok);
    int t;
    set_ch(ch);
    @(negedge clk);
    #($urandom_range(0, 4));
    set_start(1'b1);
    t = 0;
    while (!u_if.busy && t < 8) begin
      @(negedge clk);
      t++;
      if (t == 2 && !keep) set_start(1'b0);
    end
    if (!keep) set_start(1'b0);
    check_range("accept latency", t, 2, 4);
    ok = u_if.busy;
  endtask

  // One single-shot measurement; optionally disturbs start/ch_sel while busy.
  task automatic measure(input logic [1:0] ch, input bit disturb);
    int  lat, edges, busy_gap, dist_at, n_extra, exp_n, lo, hi;
    bit  ok;
    logic prev_p;
    exp_n = model_edges(int'(ch));
    lo    = (exp_n > 0) ? exp_n - 1 : 0;
    hi    = (exp_n > 0) ? exp_n + 1 : 0;
    request(ch, 1'b0, ok);
    if (!ok) return;
    lat      = 0;
    edges    = 0;
    busy_gap = 0;
    prev_p   = u_if.probe;
    dist_at  = disturb ? int'($urandom_range(20, 800)) : -10;
    while (!u_if.done && lat < DoneLat + 80) begin
      @(negedge clk);
      lat++;
      if (u_if.probe && !prev_p) edges++;
      prev_p = u_if.probe;
      if (!u_if.busy) busy_gap++;
      if (lat == dist_at) begin
        set_ch(2'($urandom_range(0, 3)));
        set_start(1'b1);
      end
      if (lat == dist_at + 3) set_start(1'b0);
    end
    check("done latency", lat, DoneLat);
    check("done small-width dut", u_if6.done, 1);
    check_range("count", u_if.count, lo, hi);
    check("overflow", u_if.overflow, 0);
    check("count sat", u_if6.count, model_sat(exp_n, CntWSmall));
    check("overflow sat", u_if6.overflow, model_ovf(exp_n, CntWSmall));
    check("busy held", busy_gap, 0);
    if (exp_n > 0) check_range("probe edges", edges, exp_n - 5, exp_n + 6);
    else           check("probe edges", edges, 0);
    @(negedge clk);
    check("done width", u_if.done, 0);
    check("busy after done", u_if.busy, 0);
    check("led after done", u_if.led, 0);
    check("probe after done", u_if.probe, 0);
    n_extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (u_if.done) n_extra++;
    end
    check("extra done", n_extra, 0);
    check_range("count hold", u_if.count, lo, hi);
  endtask

  typedef struct {
    logic [1:0] ch;
    bit         disturb;
  } vec_t;

  // Reset asserted mid-COUNT: everything clears immediately, no done follows.
  task automatic reset_mid();
    bit ok;
    int n_done, n_busy, n_probe;
    request(2'd2, 1'b0, ok);
    if (!ok) return;
    repeat (Settle + 1 + 500) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst busy", u_if.busy, 0);
    check("rst done", u_if.done, 0);
    check("rst count", u_if.count, 0);
    check("rst overflow", u_if.overflow, 0);
    check("rst led", u_if.led, 0);
    check("rst count sat", u_if6.count, 0);
    #3;
    check("rst probe", u_if.probe, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_done  = 0;
    n_busy  = 0;
    n_probe = 0;
    repeat (DoneLat + 80) begin
      @(negedge clk);
      if (u_if.done)  n_done++;
      if (u_if.busy)  n_busy++;
      if (u_if.probe) n_probe++;
    end
    check("rst no done", n_done, 0);
    check("rst no busy", n_busy, 0);
    check("rst probe flat", n_probe, 0);
  endtask

  // start held high across several windows.
  task automatic hold_start();
    bit ok;
    int t, nd, busy_gap, exp_n;
    int done_t[4];
    exp_n = model_edges(0);
    for (int i = 0; i < 4; i++) done_t[i] = 0;
    request(2'd0, 1'b1, ok);
    if (!ok) begin
      set_start(1'b0);
      return;
    end
    nd       = 0;
    busy_gap = 0;
    t        = 0;
`ifdef RO_CONTINUOUS_EN
    while (t < 4 * (DoneLat + 1)) begin
      @(negedge clk);
      t++;
      if (u_if.done) begin
        if (nd < 4) done_t[nd] = t;
        check_range("cont count", u_if.count, exp_n - 1, exp_n + 1);
        nd++;
      end
      if (nd < 3 && !u_if.busy) busy_gap++;
      if (nd == 2 && t == done_t[1] + 500) set_start(1'b0);
      if (nd >= 3 && t == done_t[2] + 40) break;
    end
    set_start(1'b0);
    check("cont done pulses", nd, 3);
    check("cont first done", done_t[0], DoneLat);
    check("cont spacing 1", done_t[1] - done_t[0], DoneLat + 1);
    check("cont spacing 2", done_t[2] - done_t[1], DoneLat + 1);
    check("cont busy held", busy_gap, 0);
    check("cont busy release", u_if.busy, 0);
`else
    while (t < 2 * DoneLat + 100) begin
      @(negedge clk);
      t++;
      if (u_if.done) begin
        if (nd == 0) done_t[0] = t;
        check_range("held count", u_if.count, exp_n - 1, exp_n + 1);
        nd++;
      end
    end
    check("held done pulses", nd, 1);
    check("held first done", done_t[0], DoneLat);
    check("held busy low", u_if.busy, 0);
    set_start(1'b0);
    repeat (5) @(negedge clk);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion by 1 ms");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   n_probe;

    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    set_start(1'b0);
    set_ch(2'd0);

    vecs[0] = '{ch: 2'd0, disturb: 1'b0};
    vecs[1] = '{ch: 2'd1, disturb: 1'b1};
    vecs[2] = '{ch: 2'd2, disturb: 1'b0};
    vecs[3] = '{ch: 2'd3, disturb: 1'b0};  // beyond NumCh: no ring enabled
    vecs[4] = '{ch: 2'd2, disturb: 1'b1};

    #100;
    check("reset busy", u_if.busy, 0);
    check("reset done", u_if.done, 0);
    check("reset count", u_if.count, 0);
    check("reset overflow", u_if.overflow, 0);
    check("reset probe", u_if.probe, 0);
    check("reset led", u_if.led, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    n_probe = 0;
    repeat (100) begin
      @(negedge clk);
      if (u_if.probe) n_probe++;
    end
    check("idle probe flat", n_probe, 0);

    for (int i = 0; i < 5; i++) measure(vecs[i].ch, vecs[i].disturb);

    for (int i = 0; i < 4; i++) begin
      measure(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    reset_mid();
    measure(2'd1, 1'b0);

    hold_start();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
